// File: rtl/fifo_arb_pkg.sv
// Shared encodings and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int k = 1; k < n; k = k * 2) r++;
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotate-priority picker: first asserted request at or after the start pointer, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int id_width = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [id_width-1:0] start,
    output logic [id_width-1:0] sel,
    output logic                any_valid
);

    always_comb begin
        sel       = '0;
        any_valid = 1'b0;
        // Scan from farthest to nearest so the closest hit to start wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[(int'(start) + k) % NUM_REQ]) begin
                sel       = id_width'((int'(start) + k) % NUM_REQ);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter feeding the async FIFO write port through a one-entry output stage.
// Optional burst lock enabled by defining FIFO_WR_ARB_BURST_LOCK_EN.
//
// state | meaning
// ARB   | free round-robin from rr_ptr
// LOCK  | only lock_id may be accepted until its last word
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int data_width = 8,
    localparam int id_width   = clog2(NUM_REQ)
) (
    input  logic                            wclk,
    input  logic                            wrst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*data_width-1:0]   req_data,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            wfull,
    output logic                            winc,
    output logic [data_width-1:0]           wdata,
    output logic [id_width-1:0]             grant_id
);

    arb_state_t          state, state_next;
    logic                out_valid;
    logic [id_width-1:0] rr_ptr;
    logic [id_width-1:0] start;
    logic [NUM_REQ-1:0]  pick_req;
    logic [id_width-1:0] sel;
    logic                any_valid;
    logic                slot_free;
    logic                accept;

`ifdef FIFO_WR_ARB_BURST_LOCK_EN
    logic [id_width-1:0] lock_id;

    assign pick_req = (state == LOCK) ? (req_valid & (NUM_REQ'(1) << lock_id)) : req_valid;
    assign start    = (state == LOCK) ? lock_id : rr_ptr;
`else
    logic unused_last;

    assign unused_last = ^req_last;
    assign pick_req    = req_valid;
    assign start       = rr_ptr;
`endif

    rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .id_width (id_width)
    ) u_pick (
        .req       (pick_req),
        .start     (start),
        .sel       (sel),
        .any_valid (any_valid)
    );

    assign slot_free = !out_valid || !wfull;
    assign accept    = wrst_n && slot_free && any_valid;
    assign req_ready = accept ? (NUM_REQ'(1) << sel) : '0;
    assign winc      = out_valid;

    always_comb begin
        state_next = state;
`ifdef FIFO_WR_ARB_BURST_LOCK_EN
        if (accept) begin
            if (state == ARB && !req_last[sel])
                state_next = LOCK;
            else if (state == LOCK && req_last[sel])
                state_next = ARB;
        end
`endif
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            state     <= ARB;
            out_valid <= 1'b0;
            wdata     <= '0;
            grant_id  <= '0;
            rr_ptr    <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                wdata     <= req_data[int'(sel)*data_width +: data_width];
                grant_id  <= sel;
                out_valid <= 1'b1;
                // In LOCK sel equals lock_id, so this also resumes after the locked requester.
                rr_ptr    <= (sel == id_width'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
            end else if (out_valid && !wfull) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef FIFO_WR_ARB_BURST_LOCK_EN
    always_ff @(posedge wclk) begin
        if (!wrst_n)
            lock_id <= '0;
        else if (accept && state == ARB && !req_last[sel])
            lock_id <= sel;
    end
`endif

endmodule
